// File: rtl/alu_pkg.sv
// Shared definitions for the arithmetic slice: operation select encoding.
package alu_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t ALU_ADD  = 2'b00;
  localparam sel_t ALU_SUB  = 2'b01;
  localparam sel_t ALU_INC  = 2'b10;
  localparam sel_t ALU_PASS = 2'b11;

endpackage

// File: rtl/alu_adder8.sv
// Combinational ripple-carry adder; a + b + cin with carry out of the MSB.
module alu_adder8 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[WIDTH];

endmodule

// File: rtl/alua.sv
// Arithmetic ALU slice: one shared adder for ADD/SUB/INC, PASS bypasses it.
// Result and C/V flags are registered; synchronous active-high reset.
module alua
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  sel_t             SEL,
  output logic [WIDTH-1:0] OUT,
  output logic             V,
  output logic             C
);

  logic [WIDTH-1:0] w_add_b;
  logic             w_cin;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  logic [WIDTH-1:0] r_out;
  logic             r_v;
  logic             r_c;

  // SUB is A + ~B + 1, INC is A + 0 + 1; PASS value here is don't-care.
  always_comb begin
    w_add_b = B;
    w_cin   = 1'b0;
    unique case (SEL)
      ALU_ADD:  begin w_add_b = B;               w_cin = 1'b0; end
      ALU_SUB:  begin w_add_b = ~B;              w_cin = 1'b1; end
      ALU_INC:  begin w_add_b = '0;              w_cin = 1'b1; end
      default:  begin w_add_b = '0;              w_cin = 1'b0; end
    endcase
  end

  alu_adder8 #(.WIDTH(WIDTH)) u_adder (
    .a    (A),
    .b    (w_add_b),
    .cin  (w_cin),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Signed overflow from the operands actually fed to the adder covers ADD, SUB and INC alike.
  assign w_ovf = (A[WIDTH-1] == w_add_b[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);

  always_comb begin
    w_res = w_sum;
    w_c   = w_cout;
    w_v   = w_ovf;
    if (SEL == ALU_PASS) begin
      w_res = A;
      w_c   = 1'b0;
      w_v   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out <= '0;
      r_v   <= 1'b0;
      r_c   <= 1'b0;
    end else begin
      r_out <= w_res;
      r_v   <= w_v;
      r_c   <= w_c;
    end
  end

  assign OUT = r_out;
  assign V   = r_v;
  assign C   = r_c;

endmodule

// File: tb/tb_alua.sv
// Scoreboard bench for alua: stimulus pushes expected results, a monitor pops after each edge.
module tb_alua;
  import alu_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] A   = '0;
  logic [7:0] B   = '0;
  sel_t       SEL = ALU_ADD;
  logic [7:0] OUT;
  logic       V;
  logic       C;

  typedef struct {
    int         id;
    logic [7:0] out;
    logic       v;
    logic       c;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_id   = 0;

  alua #(.WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .A   (A),
    .B   (B),
    .SEL (SEL),
    .OUT (OUT),
    .V   (V),
    .C   (C)
  );

  always #5 CLK = ~CLK;

  task automatic apply(input logic rst, input logic [7:0] a, input logic [7:0] b,
                       input sel_t sel, input logic [7:0] eo, input logic ev, input logic ec);
    exp_t e;
    @(negedge CLK);
    RST = rst;
    A   = a;
    B   = b;
    SEL = sel;
    e.id  = n_id;
    e.out = eo;
    e.v   = ev;
    e.c   = ec;
    n_id++;
    exp_q.push_back(e);
  endtask

  // Monitor: each edge's registered result belongs to the oldest pending expectation.
  always @(posedge CLK) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (OUT !== e.out || V !== e.v || C !== e.c) begin
        n_fail++;
        $display("FAIL vec%0d: got OUT=%02h V=%b C=%b, expected OUT=%02h V=%b C=%b",
                 e.id, OUT, V, C, e.out, e.v, e.c);
      end
    end
  end

  initial begin
    // reset held for two edges
    apply(1'b1, 8'hAA, 8'h55, ALU_ADD,  8'h00, 1'b0, 1'b0);
    apply(1'b1, 8'hAA, 8'h55, ALU_ADD,  8'h00, 1'b0, 1'b0);
    // basic ops on 0F/05
    apply(1'b0, 8'h0F, 8'h05, ALU_ADD,  8'h14, 1'b0, 1'b0);
    apply(1'b0, 8'h0F, 8'h05, ALU_SUB,  8'h0A, 1'b0, 1'b1);
    apply(1'b0, 8'h0F, 8'h05, ALU_INC,  8'h10, 1'b0, 1'b0);
    apply(1'b0, 8'h0F, 8'h05, ALU_PASS, 8'h0F, 1'b0, 1'b0);
    // ADD overflow / carry
    apply(1'b0, 8'h7F, 8'h01, ALU_ADD,  8'h80, 1'b1, 1'b0);
    apply(1'b0, 8'hFF, 8'h01, ALU_ADD,  8'h00, 1'b0, 1'b1);
    // SUB borrow / overflow / equal
    apply(1'b0, 8'h00, 8'h01, ALU_SUB,  8'hFF, 1'b0, 1'b0);
    apply(1'b0, 8'h80, 8'h01, ALU_SUB,  8'h7F, 1'b1, 1'b1);
    apply(1'b0, 8'h5A, 8'h5A, ALU_SUB,  8'h00, 1'b0, 1'b1);
    // INC edges; B set to a non-zero value that must be ignored
    apply(1'b0, 8'hFF, 8'h33, ALU_INC,  8'h00, 1'b0, 1'b1);
    apply(1'b0, 8'h7F, 8'h33, ALU_INC,  8'h80, 1'b1, 1'b0);
    // PASS with MSB set: flags must stay clear
    apply(1'b0, 8'hC3, 8'hFF, ALU_PASS, 8'hC3, 1'b0, 1'b0);
    // reset mid-stream, then release
    apply(1'b0, 8'h0F, 8'h05, ALU_ADD,  8'h14, 1'b0, 1'b0);
    apply(1'b1, 8'h0F, 8'h05, ALU_ADD,  8'h00, 1'b0, 1'b0);
    apply(1'b0, 8'h0F, 8'h05, ALU_ADD,  8'h14, 1'b0, 1'b0);

    repeat (3) @(posedge CLK);
    #2;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
